// File: rtl/bnn_layer_engine.sv
// bnn_layer_engine: binary neural network layer, one neuron per cycle.
// Each neuron fires when the XNOR popcount of the latched input against
// its weights reaches its threshold. Weights and thresholds are loaded
// through a small beat port while the engine is idle.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid/ready    input vector handshake, in_data N_IN bits
//   out_valid/ready   result handshake, out_data N_OUT bits
//   load_valid/ready  parameter load beats; load_sel 0=weight 1=thresh
//   load_data         LOAD_W-bit load payload
//   busy              high while neurons are being evaluated
module bnn_layer_engine #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 4,
    parameter int LOAD_W  = 4,
    parameter int DEF_THR = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_sel,
    input  logic [LOAD_W-1:0] load_data,
    output logic              busy
);

    localparam int CW = $clog2(N_IN + 1);
    localparam int NB = N_OUT * N_IN / LOAD_W;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [N_OUT*N_IN-1:0]   w_flat;
    logic [CW-1:0]           thr [N_OUT];
    logic [PW-1:0]           w_ptr;
    logic [TW-1:0]           t_ptr;
    logic [TW-1:0]           idx;
    logic [N_IN-1:0]         in_lat;
    logic [N_OUT-1:0]        res;
    logic [N_OUT-1:0]        res_nxt;
    logic [N_IN-1:0]         w_sel;
    logic [N_IN-1:0]         match;
    logic [CW-1:0]           pc;
    logic                    fire;
    logic                    load_fire;

    assign in_ready   = (state == IDLE);
    assign load_ready = (state == IDLE);
    assign busy       = (state == BUSY);

    // Loads are taken in IDLE even when an input is accepted on the same
    // edge; the new parameters are then in place before the first neuron.
    assign load_fire = load_valid && (state == IDLE);

    always_comb begin
        w_sel = w_flat[idx*N_IN +: N_IN];
        match = ~(in_lat ^ w_sel);
        pc    = '0;
        for (int i = 0; i < N_IN; i++) begin
            pc = pc + CW'(match[i]);
        end
        fire         = ({1'b0, pc} >= {1'b0, thr[idx]});
        res_nxt      = res;
        res_nxt[idx] = fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            w_flat    <= '0;
            w_ptr     <= '0;
            t_ptr     <= '0;
            idx       <= '0;
            in_lat    <= '0;
            res       <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                thr[j] <= CW'(DEF_THR);
            end
        end else begin
            if (load_fire) begin
                if (!load_sel) begin
                    w_flat[w_ptr*LOAD_W +: LOAD_W] <= load_data;
                    if (w_ptr == PW'(NB - 1)) begin
                        w_ptr <= '0;
                    end else begin
                        w_ptr <= w_ptr + 1'b1;
                    end
                end else begin
                    thr[t_ptr] <= load_data[CW-1:0];
                    if (t_ptr == TW'(N_OUT - 1)) begin
                        t_ptr <= '0;
                    end else begin
                        t_ptr <= t_ptr + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_lat <= in_data;
                        idx    <= '0;
                        res    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    res <= res_nxt;
                    if (idx == TW'(N_OUT - 1)) begin
                        out_data  <= res_nxt;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
